// File: rtl/ex_div.sv
// Iterative restoring divider for the EX stage: one quotient bit per clock,
// signed or unsigned, returning {remainder, quotient} while holding the pipe.
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_req_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  logic [WIDTH-1:0]  rem_reg, quo_reg, divisor_reg;
  logic              signed_reg, sign1_reg, sign2_reg;

  logic              accept;
  logic [WIDTH-1:0]  abs1, abs2, q_fix, r_fix;
  logic [WIDTH:0]    trial;

  assign accept      = start_i & ~annul_i;
  assign stall_req_o = start_i & ~annul_i & ~ready_o;

  always_comb begin
    abs1  = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs2  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    // quo_reg doubles as the dividend shift register: its MSB is the next bit to bring down
    trial = {rem_reg, quo_reg[WIDTH-1]} - {1'b0, divisor_reg};
    q_fix = (signed_reg && (sign1_reg ^ sign2_reg)) ? -quo_reg : quo_reg;
    r_fix = (signed_reg && sign1_reg) ? -rem_reg : rem_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (accept) state_next = (opdata2_i == '0) ? S_BYZERO : S_ON;
      S_BYZERO: state_next = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i)                          state_next = S_IDLE;
        else if (cnt_reg == CW'(WIDTH - 1))   state_next = S_END;
      end
      S_END:    if (!accept) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      result_o    <= '0;
      ready_o     <= 1'b0;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      divisor_reg <= '0;
      signed_reg  <= 1'b0;
      sign1_reg   <= 1'b0;
      sign2_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (accept) begin
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= abs1;
            divisor_reg <= abs2;
            signed_reg  <= signed_div_i;
            sign1_reg   <= opdata1_i[WIDTH-1];
            sign2_reg   <= opdata2_i[WIDTH-1];
          end
        end
        S_BYZERO: begin
          rem_reg <= '0;
          quo_reg <= '0;
        end
        S_ON: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (!trial[WIDTH]) begin
            rem_reg <= trial[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
          end
        end
        S_END: begin
          if (accept) begin
            ready_o  <= 1'b1;
            result_o <= {r_fix, q_fix};
          end else begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
